// File: rtl/cathero_motion_ctrl_if.sv
// Bus bundle between the game logic and the cat-hero motion controller:
// button/pixel inputs, sprite/background colours, anchor and composited pixel.
interface cathero_motion_ctrl_if;
    logic        enable;
    logic [12:0] pixel_index;
    logic        btnL;
    logic        btnR;
    logic        btnU;
    logic        print_cat;
    logic [15:0] cat_data;
    logic [15:0] bg_data;
    logic [7:0]  x_start;
    logic [7:0]  y_start;
    logic        jumping;
    logic [15:0] oled_data;

    modport master (
        output enable, pixel_index, btnL, btnR, btnU, print_cat, cat_data, bg_data,
        input  x_start, y_start, jumping, oled_data
    );

    modport slave (
        input  enable, pixel_index, btnL, btnR, btnU, print_cat, cat_data, bg_data,
        output x_start, y_start, jumping, oled_data
    );
endinterface

// File: rtl/cathero_motion_ctrl.sv
// Frame-synchronous sprite anchor controller (walk + fixed-profile jump)
// and per-pixel sprite/background compositor for the 96x64 OLED.
module cathero_motion_ctrl #(
    parameter int SPRITE_W = 17,
    parameter int GROUND_Y = 50,
    parameter int START_X  = 8,
    parameter int JUMP_H   = 12,
    parameter int MOVE_DIV = 2
) (
    input logic clock,
    input logic reset,
    cathero_motion_ctrl_if.slave bus
);
    localparam logic [12:0] LAST_PIX = 13'd6143;
    localparam logic [7:0]  X_MAX    = 8'(96 - SPRITE_W);
    localparam logic [7:0]  GROUND   = 8'(GROUND_Y);
    localparam logic [7:0]  FDIV_TOP = 8'(MOVE_DIV - 1);
    localparam logic [3:0]  RISE_TOP = 4'(JUMP_H);

    typedef enum logic [1:0] {IDLE, RISE, FALL} jumpState_e;

    jumpState_e  state_q, state_d;
    logic [12:0] pixPrev_q;
    logic        btnU_q;
    logic        jreq_q, jreq_d;
    logic [7:0]  fdiv_q, fdiv_d;
    logic [3:0]  riseCnt_q, riseCnt_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        jumping_q, jumping_d;
    logic        qTick;

    // Only the first cycle at the last pixel counts, so a stalled index ticks once.
    assign qTick = bus.enable && (bus.pixel_index == LAST_PIX) && (pixPrev_q != LAST_PIX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pixPrev_q <= '0;
            btnU_q    <= 1'b0;
            jreq_q    <= 1'b0;
            fdiv_q    <= '0;
            riseCnt_q <= '0;
            x_q       <= 8'(START_X);
            y_q       <= GROUND;
            jumping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pixPrev_q <= bus.pixel_index;
            btnU_q    <= bus.btnU;
            jreq_q    <= jreq_d;
            fdiv_q    <= fdiv_d;
            riseCnt_q <= riseCnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            jumping_q <= jumping_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (qTick) begin
            case (state_q)
                IDLE:    if (jreq_q) state_d = RISE;
                RISE:    if (riseCnt_q == RISE_TOP || y_q == 8'd0) state_d = FALL;
                FALL:    if (y_q + 8'd1 >= GROUND) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        riseCnt_d = riseCnt_q;
        y_d       = y_q;
        if (qTick) begin
            case (state_q)
                IDLE: if (jreq_q) riseCnt_d = '0;
                RISE: begin
                    if (!(riseCnt_q == RISE_TOP || y_q == 8'd0)) begin
                        y_d       = y_q - 8'd1;
                        riseCnt_d = riseCnt_q + 4'd1;
                    end
                end
                FALL: y_d = (y_q + 8'd1 >= GROUND) ? GROUND : y_q + 8'd1;
                default: ;
            endcase
        end
        jumping_d = (state_d != IDLE);
    end

    // A new press wins over the per-tick clear so an edge on the tick cycle is kept.
    always_comb begin
        jreq_d = jreq_q;
        if (bus.btnU && !btnU_q) jreq_d = 1'b1;
        else if (qTick)          jreq_d = 1'b0;
    end

    always_comb begin
        fdiv_d = fdiv_q;
        x_d    = x_q;
        if (qTick) begin
            fdiv_d = (fdiv_q == FDIV_TOP) ? 8'd0 : fdiv_q + 8'd1;
            if (fdiv_q == FDIV_TOP) begin
                if (bus.btnR && !bus.btnL && x_q < X_MAX) x_d = x_q + 8'd1;
                if (bus.btnL && !bus.btnR && x_q > 8'd0)  x_d = x_q - 8'd1;
            end
        end
    end

    assign bus.x_start   = x_q;
    assign bus.y_start   = y_q;
    assign bus.jumping   = jumping_q;
    assign bus.oled_data = bus.print_cat ? bus.cat_data : bus.bg_data;

endmodule
